sparrow_mem_arbiter: RTL and testbench
======================================

// Module: sparrow_mem_arbiter
// PURPOSE
//  Schedules the core's single external memory port between instruction fetch and the load/store path.
//  The LSU path is driven from the decoded dmem_req/dmem_wr_en/dmem_byte_en/dmem_zero_extend controls.
//  Per access the block:
//   - arbitrates between the two requesters, one outstanding bus transaction at a time;
//   - generates byte lanes and checks alignment;
//   - extracts and extends load data;
//   - bounds bus waits with a timeout.
//  It sits between the pipeline front-end/execute stage and the memory bus.
// PARAMETERS
//  TIMEOUT_CYC  16  cycles allowed in WAIT_GNT or WAIT_RSP before an error completion; 0 disables the timeout
//  CNT_W        5   timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  i_clk             in   1   clock
//  i_rst_n           in   1   asynchronous active-low reset
//  i_if_req          in   1   fetch request, level, held until o_if_rvalid
//  i_if_addr         in   32  fetch address, word aligned
//  o_if_rvalid       out  1   fetch complete, 1-cycle pulse
//  o_if_rdata        out  32  instruction, valid with o_if_rvalid
//  o_if_err          out  1   fetch bus timeout, valid with o_if_rvalid
//  i_lsu_req         in   1   data request (dmem_req), level, held until o_lsu_done
//  i_lsu_we          in   1   1 = store (dmem_wr_en)
//  i_lsu_size        in   2   0 byte, 1 half, 2 word, 3 illegal (dmem_byte_en)
//  i_lsu_zext        in   1   zero-extend load (dmem_zero_extend)
//  i_lsu_addr        in   32  byte address from ALU
//  i_lsu_wdata       in   32  store data, right-justified
//  o_lsu_done        out  1   data access complete, 1-cycle pulse
//  o_lsu_rdata       out  32  extended load data, valid with o_lsu_done; 0 for stores
//  o_lsu_err         out  1   misaligned, illegal size or timeout, valid with o_lsu_done
//  o_lsu_stall       out  1   i_lsu_req & ~o_lsu_done
//  o_mem_req         out  1   bus request
//  i_mem_gnt         in   1   bus accepts address phase
//  o_mem_addr        out  32  {addr[31:2],2'b00}
//  o_mem_we          out  1   bus write
//  o_mem_be          out  4   byte lanes
//  o_mem_wdata       out  32  lane-replicated store data
//  i_mem_rvalid      in   1   response, for both reads and writes
//  i_mem_rdata       in   32  read data
// BEHAVIOUR
//  Reset:
//   - async; state IDLE, counter 0, last_owner FETCH.
//   - All outputs 0. An in-flight transaction is dropped; any later stray i_mem_rvalid is ignored.
//  FSM IDLE -> WAIT_GNT -> WAIT_RSP -> IDLE.
//  IDLE:
//   - Winner selection: LSU wins, except fetch wins when both requests are pending and last_owner==LSU.
//   - Winner's fields are registered (owner, addr, we, be, wdata, size, zext, addr[1:0]).
//     o_mem_req rises the next cycle.
//   - Misaligned LSU request (half with addr[0], word with addr[1:0]!=0) or size 3:
//     no bus access; next cycle o_lsu_done=o_lsu_err=1, o_lsu_rdata=0; stay IDLE.
//  WAIT_GNT:
//   - o_mem_req=1; addr/we/be/wdata held stable until i_mem_gnt.
//   - On gnt: go to WAIT_RSP, drop o_mem_req, clear counter.
//  WAIT_RSP:
//   - Wait for i_mem_rvalid. On rvalid, the owner's done/rvalid pulse is combinational in that same cycle.
//   - Next state IDLE; last_owner <- owner.
//   - Requester must drop or replace its request on that edge.
//   - Minimum latency: request seen cycle 0, o_mem_req cycle 1, gnt cycle 1, rvalid/done cycle 2.
//  Timeout:
//   - Counter increments each cycle in WAIT_GNT/WAIT_RSP and clears on a state change.
//   - At TIMEOUT_CYC: complete owner with err=1, rdata 0; drop o_mem_req; return IDLE.
//  Byte lanes:
//   - byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
//  Write data:
//   - byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
//  Load data:
//   - s = i_mem_rdata >> (8*a[1:0]).
//   - byte {zext?24'b0:{24{s[7]}}, s[7:0]}; half likewise on s[15:0]; word passthrough.
//  Fetch:
//   - o_if_rdata = i_mem_rdata unmodified; i_if_addr[1:0] ignored.
//  Simultaneous events:
//   - i_mem_rvalid outside WAIT_RSP is ignored.
//   - A new request arriving in WAIT_* waits; requests are never dropped once held.
// TESTING
//  1. LSU LW addr 0x100; gnt same cycle as req, rvalid next cycle with 0xDEADBEEF -> be 1111, done cycle 2, rdata 0xDEADBEEF.
//  2. LB addr 0x103, rdata 0x80xxxxxx -> be 1000, rdata 0xFFFFFF80; LBU same -> 0x00000080.
//  3. SH addr 0x102, wdata 0x1234ABCD -> we=1, be 1100, wdata 0xABCDABCD, done on rvalid.
//  4. LW addr 0x101 -> no o_mem_req, done+err next cycle, rdata 0.
//  5. Both reqs pending back-to-back -> order LSU, FETCH, LSU, FETCH; each holds bus until its rvalid.
//  6. Gnt never asserted, TIMEOUT_CYC=16 -> done+err after 16 cycles; reset asserted in WAIT_RSP -> all outputs 0, next rvalid ignored.

Source files
------------

// File: rtl/sparrow_mem_arbiter.sv
// sparrow_mem_arbiter
//   Shares the core's single external memory port between instruction fetch
//   and the load/store path. Only one bus transaction is outstanding at a time.
//   Per access the block arbitrates, generates byte lanes, checks alignment,
//   extracts and extends load data, and bounds bus waits with a timeout.
//
// Parameters
//   TIMEOUT_CYC  cycles allowed in WAIT_GNT/WAIT_RSP before an error completion (0 = off)
//   CNT_W        timeout counter width, 2**CNT_W > TIMEOUT_CYC
//
// Ports
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_if_req/i_if_addr                  fetch request (level) and word address
//   o_if_rvalid/o_if_rdata/o_if_err     fetch completion pulse, instruction, timeout
//   i_lsu_req/we/size/zext/addr/wdata   data request (level) and decoded controls
//   o_lsu_done/o_lsu_rdata/o_lsu_err    data completion pulse, extended load, error
//   o_lsu_stall                         request pending and not completing
//   o_mem_req/addr/we/be/wdata          bus address phase (registered)
//   i_mem_gnt                           bus accepts address phase
//   i_mem_rvalid/i_mem_rdata            bus response (reads and writes)
module sparrow_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_lsu_req,
  input  logic        i_lsu_we,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_zext,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_done,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_err,
  output logic        o_lsu_stall,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_lsu;
  logic             r_owner_lsu;
  logic             r_mem_req;
  logic [31:0]      r_addr;
  logic             r_we;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic [1:0]       r_size;
  logic             r_zext;
  logic [1:0]       r_alo;
  // Registered error completions (misaligned/illegal or timeout).
  logic             r_lsu_done;
  logic             r_if_done;

  logic        w_lsu_ok;
  logic [3:0]  w_lsu_be;
  logic [31:0] w_lsu_wdata;
  logic        w_lsu_pend;
  logic        w_if_pend;
  logic        w_pick_if;
  logic        w_timeout;
  logic        w_rsp;
  logic        w_lsu_rsp;
  logic        w_if_rsp;
  logic [31:0] w_shift;
  logic [31:0] w_ld;
  logic        w_unused;

  // Fetch addresses are word aligned by contract; low bits are dropped.
  assign w_unused = ^i_if_addr[1:0];

  always_comb begin
    w_lsu_ok    = 1'b0;
    w_lsu_be    = '0;
    w_lsu_wdata = i_lsu_wdata;
    case (i_lsu_size)
      2'd0: begin
        w_lsu_ok    = 1'b1;
        w_lsu_be    = 4'b0001 << i_lsu_addr[1:0];
        w_lsu_wdata = {4{i_lsu_wdata[7:0]}};
      end
      2'd1: begin
        w_lsu_ok    = ~i_lsu_addr[0];
        w_lsu_be    = 4'b0011 << {i_lsu_addr[1], 1'b0};
        w_lsu_wdata = {2{i_lsu_wdata[15:0]}};
      end
      2'd2: begin
        w_lsu_ok    = (i_lsu_addr[1:0] == 2'b00);
        w_lsu_be    = '1;
        w_lsu_wdata = i_lsu_wdata;
      end
      default: w_lsu_ok = 1'b0;
    endcase
  end

  // A requester whose registered error pulse is on the outputs this cycle is
  // still holding its request; it must not be re-accepted.
  assign w_lsu_pend = i_lsu_req & ~r_lsu_done;
  assign w_if_pend  = i_if_req & ~r_if_done;
  assign w_pick_if  = w_if_pend & (~w_lsu_pend | r_last_lsu);

  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_last_lsu  <= 1'b0;
      r_owner_lsu <= 1'b0;
      r_mem_req   <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_zext      <= 1'b0;
      r_alo       <= '0;
      r_lsu_done  <= 1'b0;
      r_if_done   <= 1'b0;
    end else begin
      r_lsu_done <= 1'b0;
      r_if_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_pick_if) begin
            r_owner_lsu <= 1'b0;
            r_addr      <= {i_if_addr[31:2], 2'b00};
            r_we        <= 1'b0;
            r_be        <= '1;
            r_wdata     <= '0;
            r_size      <= 2'd2;
            r_zext      <= 1'b0;
            r_alo       <= '0;
            r_mem_req   <= 1'b1;
            r_state     <= ST_WAIT_GNT;
          end else if (w_lsu_pend) begin
            if (w_lsu_ok) begin
              r_owner_lsu <= 1'b1;
              r_addr      <= {i_lsu_addr[31:2], 2'b00};
              r_we        <= i_lsu_we;
              r_be        <= w_lsu_be;
              r_wdata     <= w_lsu_wdata;
              r_size      <= i_lsu_size;
              r_zext      <= i_lsu_zext;
              r_alo       <= i_lsu_addr[1:0];
              r_mem_req   <= 1'b1;
              r_state     <= ST_WAIT_GNT;
            end else begin
              r_lsu_done <= 1'b1;
            end
          end
        end
        ST_WAIT_GNT: begin
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_WAIT_RSP;
          end else if (w_timeout) begin
            r_mem_req  <= 1'b0;
            r_cnt      <= '0;
            r_last_lsu <= r_owner_lsu;
            r_lsu_done <= r_owner_lsu;
            r_if_done  <= ~r_owner_lsu;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_RSP: begin
          if (i_mem_rvalid) begin
            r_cnt      <= '0;
            r_last_lsu <= r_owner_lsu;
            r_state    <= ST_IDLE;
          end else if (w_timeout) begin
            r_cnt      <= '0;
            r_last_lsu <= r_owner_lsu;
            r_lsu_done <= r_owner_lsu;
            r_if_done  <= ~r_owner_lsu;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_rsp     = (r_state == ST_WAIT_RSP) & i_mem_rvalid;
  assign w_lsu_rsp = w_rsp & r_owner_lsu;
  assign w_if_rsp  = w_rsp & ~r_owner_lsu;

  assign w_shift = i_mem_rdata >> {r_alo, 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_ld = {r_zext ? 24'h0 : {24{w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_ld = {r_zext ? 16'h0 : {16{w_shift[15]}}, w_shift[15:0]};
      default: w_ld = i_mem_rdata;
    endcase
  end

  assign o_if_rvalid = r_if_done | w_if_rsp;
  assign o_if_rdata  = w_if_rsp ? i_mem_rdata : '0;
  assign o_if_err    = r_if_done;

  assign o_lsu_done  = r_lsu_done | w_lsu_rsp;
  assign o_lsu_rdata = (w_lsu_rsp & ~r_we) ? w_ld : '0;
  assign o_lsu_err   = r_lsu_done;
  assign o_lsu_stall = i_lsu_req & ~o_lsu_done;

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_addr;
  assign o_mem_we    = r_we;
  assign o_mem_be    = r_be;
  assign o_mem_wdata = r_wdata;

endmodule

// File: tb/tb_sparrow_mem_arbiter.sv
module tb_sparrow_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        o_if_err;
  logic        i_lsu_req = 1'b0;
  logic        i_lsu_we = 1'b0;
  logic [1:0]  i_lsu_size = '0;
  logic        i_lsu_zext = 1'b0;
  logic [31:0] i_lsu_addr = '0;
  logic [31:0] i_lsu_wdata = '0;
  logic        o_lsu_done;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_err;
  logic        o_lsu_stall;
  logic        o_mem_req;
  logic        i_mem_gnt = 1'b0;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  always #5 clk = ~clk;

  sparrow_mem_arbiter #(
    .TIMEOUT_CYC (16),
    .CNT_W       (5)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_if_req     (i_if_req),
    .i_if_addr    (i_if_addr),
    .o_if_rvalid  (o_if_rvalid),
    .o_if_rdata   (o_if_rdata),
    .o_if_err     (o_if_err),
    .i_lsu_req    (i_lsu_req),
    .i_lsu_we     (i_lsu_we),
    .i_lsu_size   (i_lsu_size),
    .i_lsu_zext   (i_lsu_zext),
    .i_lsu_addr   (i_lsu_addr),
    .i_lsu_wdata  (i_lsu_wdata),
    .o_lsu_done   (o_lsu_done),
    .o_lsu_rdata  (o_lsu_rdata),
    .o_lsu_err    (o_lsu_err),
    .o_lsu_stall  (o_lsu_stall),
    .o_mem_req    (o_mem_req),
    .i_mem_gnt    (i_mem_gnt),
    .o_mem_addr   (o_mem_addr),
    .o_mem_we     (o_mem_we),
    .o_mem_be     (o_mem_be),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        zext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        bus;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   issue;
    int   gnts;
  } lsu_exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  vec_t        lsu_q[$];
  lsu_exp_t    lsu_sb[$];
  logic [31:0] if_q[$];
  logic [31:0] if_sb[$];
  logic        order_q[$];
  int          lsu_done_n = 0;
  int          if_done_n = 0;

  // bus slave controls and captured address phase
  logic        gnt_en = 1'b1;
  logic        rsp_en = 1'b1;
  logic        fixed_en = 1'b1;
  logic [31:0] rsp_word = '0;
  int          stray_cyc = -1;
  int          gnt_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] cap_addr = '0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_be = '0;
  logic [31:0] cap_wdata = '0;

  vec_t vt[16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mdl(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic zext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mrdata, input logic bus, input logic [3:0] be,
                              input logic [31:0] ewd, input logic [31:0] erd,
                              input logic err, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.zext = zext; v.addr = addr; v.wdata = wdata;
    v.mrdata = mrdata; v.bus = bus; v.be = be; v.ewd = ewd; v.erd = erd;
    v.err = err; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Memory slave: grants when enabled, answers the cycle after a grant.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) pend = 1'b0;
    if (pend && rsp_en) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = fixed_en ? rsp_word : mdl(cap_addr);
      pend = 1'b0;
    end else if (cyc == stray_cyc) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h5A5A_5A5A;
    end else begin
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = $urandom();
    end
    i_mem_gnt = gnt_en & o_mem_req;
    @(negedge clk);
    if (i_mem_gnt && o_mem_req) begin
      pend = 1'b1;
      gnt_cnt++;
      cap_addr  = o_mem_addr;
      cap_we    = o_mem_we;
      cap_be    = o_mem_be;
      cap_wdata = o_mem_wdata;
    end
  end

  // LSU requester and scoreboard
  always begin : lsu_agent
    vec_t     cur;
    lsu_exp_t e;
    logic     done_prev;
    done_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        i_lsu_req = 1'b0;
        lsu_sb.delete();
        done_prev = 1'b0;
      end else begin
        if (done_prev) i_lsu_req = 1'b0;
        if (!i_lsu_req && lsu_q.size() > 0) begin
          cur = lsu_q.pop_front();
          i_lsu_req   = 1'b1;
          i_lsu_we    = cur.we;
          i_lsu_size  = cur.size;
          i_lsu_zext  = cur.zext;
          i_lsu_addr  = cur.addr;
          i_lsu_wdata = cur.wdata;
          e.v = cur;
          e.issue = cyc;
          e.gnts = gnt_cnt;
          lsu_sb.push_back(e);
        end
      end
      @(negedge clk);
      done_prev = o_lsu_done;
      if (o_lsu_done) begin
        lsu_done_n++;
        order_q.push_back(1'b1);
        if (lsu_sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL lsu_unexpected_done: actual=1 required=0");
        end else begin
          e = lsu_sb.pop_front();
          chk("lsu_rdata", o_lsu_rdata, e.v.erd);
          chk("lsu_err", {31'b0, o_lsu_err}, {31'b0, e.v.err});
          chk("lsu_stall_at_done", {31'b0, o_lsu_stall}, 32'd0);
          if (e.v.lat > 0) chk("lsu_latency", cyc - e.issue, e.v.lat);
          if (e.v.bus) begin
            chk("lsu_bus_addr", cap_addr, {e.v.addr[31:2], 2'b00});
            chk("lsu_bus_we", {31'b0, cap_we}, {31'b0, e.v.we});
            chk("lsu_bus_be", {28'b0, cap_be}, {28'b0, e.v.be});
            chk("lsu_bus_wdata", cap_wdata, e.v.ewd);
          end else begin
            chk("lsu_no_grant", gnt_cnt - e.gnts, 0);
            chk("lsu_req_low_on_err", {31'b0, o_mem_req}, 32'd0);
          end
        end
      end
    end
  end

  // Fetch requester and scoreboard
  always begin : if_agent
    logic [31:0] a;
    logic        done_prev;
    done_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        i_if_req = 1'b0;
        if_sb.delete();
        done_prev = 1'b0;
      end else begin
        if (done_prev) i_if_req = 1'b0;
        if (!i_if_req && if_q.size() > 0) begin
          a = if_q.pop_front();
          i_if_req  = 1'b1;
          i_if_addr = a;
          if_sb.push_back(a);
        end
      end
      @(negedge clk);
      done_prev = o_if_rvalid;
      if (o_if_rvalid) begin
        if_done_n++;
        order_q.push_back(1'b0);
        if (if_sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL if_unexpected_rvalid: actual=1 required=0");
        end else begin
          a = if_sb.pop_front();
          chk("if_rdata", o_if_rdata, mdl({a[31:2], 2'b00}));
          chk("if_err", {31'b0, o_if_err}, 32'd0);
          chk("if_bus_addr", cap_addr, {a[31:2], 2'b00});
          chk("if_bus_we", {31'b0, cap_we}, 32'd0);
          chk("if_bus_be", {28'b0, cap_be}, 32'hF);
        end
      end
    end
  end

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(lsu_q.size() == 0 && lsu_sb.size() == 0 && if_q.size() == 0 &&
                 if_sb.size() == 0 && !i_lsu_req && !i_if_req) && n < max);
    if (n >= max) begin
      total++;
      bad++;
      $display("FAIL wait_idle: actual=busy required=idle after %0d cycles", max);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic any_req;
    logic any_done;
    int   d0;
    logic exp_order[4];

    //          we size zx addr          wdata         mem rdata     bus be       exp wdata     exp rdata     err lat
    vt[0]  = mk(0, 2, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0, 2);
    vt[1]  = mk(0, 0, 0, 32'h0000_0103, 32'h0,        32'h8012_3456, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 0, 2);
    vt[2]  = mk(0, 0, 1, 32'h0000_0103, 32'h0,        32'h8012_3456, 1, 4'b1000, 32'h0,        32'h0000_0080, 0, 2);
    vt[3]  = mk(1, 1, 0, 32'h0000_0102, 32'h1234_ABCD, 32'h55AA_55AA, 1, 4'b1100, 32'hABCD_ABCD, 32'h0,        0, 2);
    vt[4]  = mk(0, 2, 0, 32'h0000_0101, 32'h0,        32'h1111_1111, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    vt[5]  = mk(0, 1, 0, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 4'b1100, 32'h0,        32'hFFFF_8001, 0, 2);
    vt[6]  = mk(0, 1, 1, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 4'b1100, 32'h0,        32'h0000_8001, 0, 2);
    vt[7]  = mk(0, 1, 0, 32'h0000_0100, 32'h0,        32'h1234_F00D, 1, 4'b0011, 32'h0,        32'hFFFF_F00D, 0, 2);
    vt[8]  = mk(1, 0, 0, 32'h0000_0101, 32'hFFFF_FF5A, 32'h0,        1, 4'b0010, 32'h5A5A_5A5A, 32'h0,        0, 2);
    vt[9]  = mk(1, 2, 0, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,        1, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 2);
    vt[10] = mk(0, 1, 0, 32'h0000_0101, 32'h0,        32'h2222_2222, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    vt[11] = mk(0, 3, 0, 32'h0000_0200, 32'h0,        32'h3333_3333, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    vt[12] = mk(0, 0, 0, 32'h0000_0102, 32'h0,        32'h007F_0000, 1, 4'b0100, 32'h0,        32'h0000_007F, 0, 2);
    vt[13] = mk(0, 2, 0, 32'h0000_0102, 32'h0,        32'h4444_4444, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    vt[14] = mk(0, 0, 1, 32'h0000_0101, 32'h0,        32'h0000_C300, 1, 4'b0010, 32'h0,        32'h0000_00C3, 0, 2);
    vt[15] = mk(0, 0, 0, 32'h0000_0101, 32'h0,        32'h0000_C300, 1, 4'b0010, 32'h0,        32'hFFFF_FFC3, 0, 2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", {31'b0, o_mem_req}, 32'd0);
    chk("reset_lsu_done", {31'b0, o_lsu_done}, 32'd0);
    chk("reset_if_rvalid", {31'b0, o_if_rvalid}, 32'd0);
    chk("reset_mem_be", {28'b0, o_mem_be}, 32'd0);
    chk("reset_mem_addr", o_mem_addr, 32'd0);
    rst_n = 1'b1;

    fixed_en = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      rsp_word = vt[i].mrdata;
      lsu_q.push_back(vt[i]);
      wait_idle(40);
    end

    // grant never comes: error completion 16 cycles after o_mem_req rises
    gnt_en = 1'b0;
    lsu_q.push_back(mk(0, 2, 0, 32'h0000_0300, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1, 17));
    wait_idle(60);
    gnt_en = 1'b1;

    // reset while waiting for the response; a later rvalid must be ignored
    rsp_en = 1'b0;
    d0 = gnt_cnt;
    lsu_q.push_back(mk(0, 2, 0, 32'h0000_0400, 32'h0, 32'h0, 1, 4'b1111, 32'h0, 32'h0, 0, 0));
    repeat (4) begin
      @(posedge clk);
      #2;
    end
    chk("granted_before_reset", gnt_cnt - d0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, o_mem_req}, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, o_mem_be}, 32'd0);
    chk("rst_mem_we", {31'b0, o_mem_we}, 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    chk("rst_lsu_done", {31'b0, o_lsu_done}, 32'd0);
    chk("rst_lsu_rdata", o_lsu_rdata, 32'd0);
    chk("rst_if_rdata", o_if_rdata, 32'd0);
    @(posedge clk);
    #2;
    chk("rst_lsu_stall", {31'b0, o_lsu_stall}, 32'd0);
    rst_n = 1'b1;
    rsp_en = 1'b1;
    d0 = lsu_done_n + if_done_n;
    stray_cyc = cyc + 2;
    any_req = 1'b0;
    any_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_req  = any_req | o_mem_req;
      any_done = any_done | o_lsu_done | o_if_rvalid;
    end
    chk("stray_rvalid_no_done", {31'b0, any_done}, 32'd0);
    chk("stray_rvalid_done_count", lsu_done_n + if_done_n - d0, 0);
    chk("after_reset_no_req", {31'b0, any_req}, 32'd0);

    // both requesters back-to-back: fetch gets the bus after each LSU access
    fixed_en = 1'b0;
    order_q.delete();
    lsu_q.push_back(mk(0, 2, 0, 32'h0000_2000, 32'h0, 32'h0, 1, 4'b1111, 32'h0, mdl(32'h0000_2000), 0, 2));
    lsu_q.push_back(mk(0, 2, 0, 32'h0000_2004, 32'h0, 32'h0, 1, 4'b1111, 32'h0, mdl(32'h0000_2004), 0, 0));
    if_q.push_back(32'h0000_1000);
    if_q.push_back(32'h0000_1006);
    wait_idle(60);
    exp_order[0] = 1'b1;
    exp_order[1] = 1'b0;
    exp_order[2] = 1'b1;
    exp_order[3] = 1'b0;
    chk("order_len", order_q.size(), 4);
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < order_q.size()) chk($sformatf("order_%0d", i), {31'b0, order_q[i]}, {31'b0, exp_order[i]});
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
